// File: rtl/raw_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : raw_scoreboard_if
// Brief    : Issue / writeback / load-return / status bundle between the
//            pipeline control and the RAW scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface raw_scoreboard_if #(
  parameter int NREG   = 32,
  parameter int PERF_W = 16
);
  localparam int ADDR_W = $clog2(NREG);

  // Issue stage request
  logic              issue_valid_i;
  logic              issue_rd_en_i;
  logic [ADDR_W-1:0] issue_rd_addr_i;
  logic              issue_is_load_i;
  logic              issue_rs1_en_i;
  logic [ADDR_W-1:0] issue_rs1_addr_i;
  logic              issue_rs2_en_i;
  logic [ADDR_W-1:0] issue_rs2_addr_i;
  logic              issue_ready_o;

  // Retirement and load-return events
  logic              wb_valid_i;
  logic [ADDR_W-1:0] wb_rd_addr_i;
  logic              ld_ret_valid_i;
  logic [ADDR_W-1:0] ld_ret_rd_addr_i;
  logic              flush_i;

  // Status towards forwarding unit and pipeline control
  logic              rs1_pending_o;
  logic              rs2_pending_o;
  logic              busy_o;
  logic              stall_o;
  logic [PERF_W-1:0] stall_cnt_o;
  logic              err_o;

  // Pipeline-control side: drives events, observes readiness/status
  modport master (
    output issue_valid_i, issue_rd_en_i, issue_rd_addr_i, issue_is_load_i,
    output issue_rs1_en_i, issue_rs1_addr_i, issue_rs2_en_i, issue_rs2_addr_i,
    output wb_valid_i, wb_rd_addr_i, ld_ret_valid_i, ld_ret_rd_addr_i, flush_i,
    input  issue_ready_o, rs1_pending_o, rs2_pending_o, busy_o,
    input  stall_o, stall_cnt_o, err_o
  );

  // Scoreboard side
  modport slave (
    input  issue_valid_i, issue_rd_en_i, issue_rd_addr_i, issue_is_load_i,
    input  issue_rs1_en_i, issue_rs1_addr_i, issue_rs2_en_i, issue_rs2_addr_i,
    input  wb_valid_i, wb_rd_addr_i, ld_ret_valid_i, ld_ret_rd_addr_i, flush_i,
    output issue_ready_o, rs1_pending_o, rs2_pending_o, busy_o,
    output stall_o, stall_cnt_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/raw_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : raw_scoreboard
// Brief    : Tracks in-flight register writes from issue to writeback and
//            stalls issue only when a source cannot be forwarded (load-use,
//            or a saturated in-flight counter). Keeps a stall-cycle counter
//            and a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module raw_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  raw_scoreboard_if.slave sb
);

  localparam int ADDR_W = $clog2(NREG);

  localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [PERF_W-1:0] c_perf_max = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] c_perf_one = PERF_W'(1);

  localparam logic [0:0] c_st_run   = 1'b0;
  localparam logic [0:0] c_st_stall = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic [NREG-1:0]   r_ld;
  logic [0:0]        r_state;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              r_err;

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  w_cnt_nxt [NREG];
  logic [NREG-1:0]   w_ld_nxt;
  logic [NREG-1:0]   w_inc_vec;
  logic [NREG-1:0]   w_dec_vec;
  logic [NREG-1:0]   w_ret_vec;

  logic              w_rs1_nz;
  logic              w_rs2_nz;
  logic              w_rd_nz;
  logic              w_wb_nz;
  logic              w_ret_nz;
  logic [CNT_W-1:0]  w_rs1_cnt;
  logic [CNT_W-1:0]  w_rs2_cnt;
  logic [CNT_W-1:0]  w_rd_cnt;
  logic [CNT_W-1:0]  w_wb_cnt;
  logic              w_rs1_hz;
  logic              w_rs2_hz;
  logic              w_rd_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_stall_cond;
  logic              w_wb_err;
  logic              w_ld_err;
  logic              w_busy;
  logic [0:0]        w_state_nxt;

  // --------------------------------------------------------------------------
  // Operand lookups. Register 0 is never tracked, so a zero address is
  // masked out explicitly rather than relying on entry 0 staying clear.
  // --------------------------------------------------------------------------
  assign w_rs1_nz  = sb.issue_rs1_en_i && (sb.issue_rs1_addr_i != '0);
  assign w_rs2_nz  = sb.issue_rs2_en_i && (sb.issue_rs2_addr_i != '0);
  assign w_rd_nz   = sb.issue_rd_en_i  && (sb.issue_rd_addr_i  != '0);
  assign w_wb_nz   = sb.wb_valid_i     && (sb.wb_rd_addr_i     != '0);
  assign w_ret_nz  = sb.ld_ret_valid_i && (sb.ld_ret_rd_addr_i != '0);

  assign w_rs1_cnt = r_cnt[sb.issue_rs1_addr_i];
  assign w_rs2_cnt = r_cnt[sb.issue_rs2_addr_i];
  assign w_rd_cnt  = r_cnt[sb.issue_rd_addr_i];
  assign w_wb_cnt  = r_cnt[sb.wb_rd_addr_i];

  // A source is unforwardable while its youngest writer is a load whose data
  // has not returned, or while the counter is saturated (the forwarding unit
  // cannot disambiguate more writers than the counter can hold).
  assign w_rs1_hz  = w_rs1_nz && (r_ld[sb.issue_rs1_addr_i] || (w_rs1_cnt == c_cnt_max));
  assign w_rs2_hz  = w_rs2_nz && (r_ld[sb.issue_rs2_addr_i] || (w_rs2_cnt == c_cnt_max));

  // One more writer would overflow the destination counter.
  assign w_rd_full = w_rd_nz && (w_rd_cnt == c_cnt_max);

  assign w_ready      = !sb.flush_i && !w_rs1_hz && !w_rs2_hz && !w_rd_full;
  assign w_accept     = sb.issue_valid_i && w_ready;
  assign w_stall_cond = sb.issue_valid_i && !w_ready && !sb.flush_i;

  // Protocol errors: retiring a register with nothing in flight, or a load
  // return for a register with no outstanding load.
  assign w_wb_err  = w_wb_nz  && (w_wb_cnt == '0);
  assign w_ld_err  = w_ret_nz && !r_ld[sb.ld_ret_rd_addr_i];

  // Decode the three per-register events into one-hot vectors.
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    w_ret_vec = '0;
    if (w_accept && w_rd_nz) begin
      w_inc_vec[sb.issue_rd_addr_i] = 1'b1;
    end
    if (w_wb_nz && (w_wb_cnt != '0)) begin
      w_dec_vec[sb.wb_rd_addr_i] = 1'b1;
    end
    if (w_ret_nz) begin
      w_ret_vec[sb.ld_ret_rd_addr_i] = 1'b1;
    end
  end

  // Per-register next state. A same-cycle issue and retire cancel out; a
  // same-cycle issue always decides the load flag over a load return.
  always_comb begin
    w_ld_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_ld_nxt[i]  = r_ld[i];
      if (i == 0 || sb.flush_i) begin
        w_cnt_nxt[i] = '0;
        w_ld_nxt[i]  = 1'b0;
      end else begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          w_cnt_nxt[i] = r_cnt[i] + c_cnt_one;
        end else if (!w_inc_vec[i] && w_dec_vec[i]) begin
          w_cnt_nxt[i] = r_cnt[i] - c_cnt_one;
        end
        if (w_inc_vec[i]) begin
          w_ld_nxt[i] = sb.issue_is_load_i;
        end else if (w_ret_vec[i]) begin
          w_ld_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Register file of in-flight counters and pending-load flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_ld <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_ld <= w_ld_nxt;
    end
  end

  // Any register with a nonzero counter means writes are still in flight.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_busy = w_busy | (r_cnt[i] != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Stall FSM: enter STALL on a blocked issue, leave once the instruction is
  // accepted or withdrawn.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run: begin
        if (w_stall_cond) begin
          w_state_nxt = c_st_stall;
        end
      end
      c_st_stall: begin
        if (w_accept || !sb.issue_valid_i) begin
          w_state_nxt = c_st_run;
        end
      end
      default: w_state_nxt = c_st_run;
    endcase
  end

  // FSM state, saturating stall-cycle counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_run;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_cond && (r_stall_cnt != c_perf_max)) begin
        r_stall_cnt <= r_stall_cnt + c_perf_one;
      end
      // A flush squashes the cycle's wb/load-return, so they cannot err.
      if (!sb.flush_i && (w_wb_err || w_ld_err)) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sb.issue_ready_o = w_ready;
  assign sb.rs1_pending_o = w_rs1_nz && (w_rs1_cnt != '0);
  assign sb.rs2_pending_o = w_rs2_nz && (w_rs2_cnt != '0);
  assign sb.busy_o        = w_busy;
  assign sb.stall_o       = (r_state == c_st_stall);
  assign sb.stall_cnt_o   = r_stall_cnt;
  assign sb.err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_raw_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_scoreboard
// Brief    : Scoreboard bench for raw_scoreboard: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raw_scoreboard;

  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raw_scoreboard_if #(.NREG(NREG), .PERF_W(PERF_W)) sb_if ();

  raw_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  typedef struct {
    bit valid; bit rd_en; int rd; bit is_load;
    bit rs1_en; int rs1; bit rs2_en; int rs2;
    bit wb_v; int wb_rd; bit lr_v; int lr_rd; bit flush;
  } stim_t;

  typedef struct {
    bit ready; bit p1; bit p2; bit busy; bit stall; bit err; int scnt;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: outstanding-writer count and pending-load flag per reg.
  int m_cnt [NREG];
  bit m_ld  [NREG];
  bit m_stall;
  bit m_err;
  int m_scnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit v, bit rde, int rd, bit ld, bit r1e, int r1,
                               bit r2e, int r2, bit wbv = 0, int wbr = 0,
                               bit lrv = 0, int lrr = 0, bit fl = 0);
    stim_t s;
    s.valid = v;   s.rd_en = rde;  s.rd = rd;   s.is_load = ld;
    s.rs1_en = r1e; s.rs1 = r1;    s.rs2_en = r2e; s.rs2 = r2;
    s.wb_v = wbv;  s.wb_rd = wbr;  s.lr_v = lrv; s.lr_rd = lrr; s.flush = fl;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    sb_if.issue_valid_i    = s.valid;
    sb_if.issue_rd_en_i    = s.rd_en;
    sb_if.issue_rd_addr_i  = 5'(s.rd);
    sb_if.issue_is_load_i  = s.is_load;
    sb_if.issue_rs1_en_i   = s.rs1_en;
    sb_if.issue_rs1_addr_i = 5'(s.rs1);
    sb_if.issue_rs2_en_i   = s.rs2_en;
    sb_if.issue_rs2_addr_i = 5'(s.rs2);
    sb_if.wb_valid_i       = s.wb_v;
    sb_if.wb_rd_addr_i     = 5'(s.wb_rd);
    sb_if.ld_ret_valid_i   = s.lr_v;
    sb_if.ld_ret_rd_addr_i = 5'(s.lr_rd);
    sb_if.flush_i          = s.flush;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_cnt[i] = 0;
      m_ld[i]  = 1'b0;
    end
  endfunction

  function automatic bit src_blocked(bit en, int a);
    return en && a != 0 && (m_ld[a] || m_cnt[a] == CMAX);
  endfunction

  function automatic bit model_ready(stim_t s);
    return !s.flush && !src_blocked(s.rs1_en, s.rs1) && !src_blocked(s.rs2_en, s.rs2)
           && !(s.rd_en && s.rd != 0 && m_cnt[s.rd] == CMAX);
  endfunction

  // Drive one cycle: expected outputs for this cycle go to the scoreboard
  // queue, then the model advances across the coming clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit   rdy;
    bit   acc;
    bit   dec;
    apply(s);
    rdy     = model_ready(s);
    e.ready = rdy;
    e.p1    = s.rs1_en && s.rs1 != 0 && m_cnt[s.rs1] > 0;
    e.p2    = s.rs2_en && s.rs2 != 0 && m_cnt[s.rs2] > 0;
    e.busy  = 1'b0;
    for (int i = 1; i < NREG; i++) if (m_cnt[i] > 0) e.busy = 1'b1;
    e.stall = m_stall;
    e.err   = m_err;
    e.scnt  = m_scnt;
    sbq.push_back(e);

    acc = s.valid && rdy;
    if (s.valid && !rdy && !s.flush && m_scnt < PMAX) m_scnt++;
    m_stall = s.valid && !acc && (m_stall || !s.flush);
    if (s.flush) begin
      model_clear();
    end else begin
      dec = 1'b0;
      if (s.wb_v && s.wb_rd != 0) begin
        if (m_cnt[s.wb_rd] == 0) m_err = 1'b1;
        else dec = 1'b1;
      end
      if (s.lr_v && s.lr_rd != 0 && !m_ld[s.lr_rd]) m_err = 1'b1;
      if (dec) m_cnt[s.wb_rd]--;
      if (s.lr_v && s.lr_rd != 0) m_ld[s.lr_rd] = 1'b0;
      if (acc && s.rd_en && s.rd != 0) begin
        m_cnt[s.rd]++;
        m_ld[s.rd] = s.is_load;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    apply(mk(1, 1, 4, 0, 1, 4, 1, 0));
    rst_n = 1'b0;
    #1;
    model_clear();
    m_stall = 1'b0;
    m_err   = 1'b0;
    m_scnt  = 0;
    chk("rst_stall",       32'(sb_if.stall_o),       32'd0);
    chk("rst_stall_cnt",   32'(sb_if.stall_cnt_o),   32'd0);
    chk("rst_err",         32'(sb_if.err_o),         32'd0);
    chk("rst_busy",        32'(sb_if.busy_o),        32'd0);
    chk("rst_ready",       32'(sb_if.issue_ready_o), 32'd1);
    chk("rst_rs1_pending", 32'(sb_if.rs1_pending_o), 32'd0);
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    int    wcand[$];
    int    lcand[$];
    for (int i = 1; i < 8; i++) begin
      if (m_cnt[i] > 0) wcand.push_back(i);
      if (m_ld[i])      lcand.push_back(i);
    end
    s.valid   = ($urandom % 10) < 7;
    s.rd_en   = ($urandom % 5) != 0;
    s.rd      = $urandom % 8;
    s.is_load = ($urandom % 10) < 3;
    s.rs1_en  = $urandom % 2;
    s.rs1     = $urandom % 8;
    s.rs2_en  = $urandom % 2;
    s.rs2     = $urandom % 8;
    s.wb_v    = ($urandom % 10) < 4;
    if (wcand.size() > 0 && ($urandom % 10) != 0) s.wb_rd = wcand[$urandom % wcand.size()];
    else s.wb_rd = $urandom % 8;
    s.lr_v    = ($urandom % 10) < 3;
    if (lcand.size() > 0 && ($urandom % 10) != 0) s.lr_rd = lcand[$urandom % lcand.size()];
    else s.lr_rd = 1 + ($urandom % 7);
    s.flush   = ($urandom % 40) == 0;
    return s;
  endfunction

  // Monitor: pops one expectation per presented cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("issue_ready", 32'(sb_if.issue_ready_o), 32'(e.ready));
        chk("rs1_pending", 32'(sb_if.rs1_pending_o), 32'(e.p1));
        chk("rs2_pending", 32'(sb_if.rs2_pending_o), 32'(e.p2));
        chk("busy",        32'(sb_if.busy_o),        32'(e.busy));
        chk("stall",       32'(sb_if.stall_o),       32'(e.stall));
        chk("stall_cnt",   32'(sb_if.stall_cnt_o),   32'(e.scnt));
        chk("err",         32'(sb_if.err_o),         32'(e.err));
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    model_clear();
    m_stall = 1'b0;
    m_err   = 1'b0;
    m_scnt  = 0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    // Forwardable ALU dependency
    step(mk(1, 1, 5, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 1, 5, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Load-use stall until the load returns
    step(mk(1, 1, 7, 1, 0, 0, 0, 0));
    repeat (3) step(mk(1, 0, 0, 0, 0, 0, 1, 7));
    step(mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7));
    step(mk(1, 0, 0, 0, 0, 0, 1, 7));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7));

    // Counter saturation on x9
    repeat (3) step(mk(1, 1, 9, 0, 0, 0, 0, 0));
    step(mk(1, 1, 9, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 1, 9, 0, 0));
    step(mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 9));
    step(mk(1, 1, 9, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 1, 9, 0, 0, 1, 9));
    step(mk(1, 0, 0, 0, 1, 9, 0, 0));
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9));

    // Flush with concurrent writeback
    step(mk(1, 1, 4, 1, 0, 0, 0, 0));
    step(mk(1, 1, 6, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 1, 4, 0, 0, 1, 6, 0, 0, 1));
    step(mk(1, 0, 0, 0, 1, 4, 0, 0));

    // Same-cycle issue + writeback, then double retire -> sticky error
    step(mk(1, 1, 3, 0, 0, 0, 0, 0));
    step(mk(1, 1, 3, 0, 0, 0, 0, 0, 1, 3));
    step(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // x0 traffic is never tracked
    step(mk(1, 1, 0, 1, 1, 0, 1, 0));
    step(mk(1, 1, 0, 0, 1, 0, 1, 0, 1, 0));

    // Reset while stalled
    step(mk(1, 1, 4, 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 1, 4, 0, 0));
    step(mk(1, 0, 0, 0, 1, 4, 0, 0));
    do_reset();

    // Randomized traffic in independent phases
    for (int ph = 0; ph < 4; ph++) begin
      repeat (300) step(rnd());
      do_reset();
    end

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
